// File: rtl/bus_arb_pkg.sv
// Shared constants and the FSM state type for the three-master memory bus arbiter.
package bus_arb_pkg;

  localparam int NM_DEF = 3;
  localparam int M_VGA  = 0;
  localparam int M_UART = 1;
  localparam int M_CPU  = 2;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner select: starved requesters first, then the lowest index.
module bus_arb_pick
  import bus_arb_pkg::*;
#(
  parameter int NM = NM_DEF
) (
  input  logic [NM-1:0] i_req,
  input  logic [NM-1:0] i_excl,
  input  logic [NM-1:0] i_starved,
  output logic [NM-1:0] o_win,
  output logic          o_vld
);

  logic [NM-1:0] w_elig;
  logic [NM-1:0] w_starv;
  logic [NM-1:0] w_pool;

  always_comb begin
    w_elig  = i_req & ~i_excl;
    w_starv = w_elig & i_starved;
    w_pool  = (|w_starv) ? w_starv : w_elig;
    // Two's-complement trick isolates the lowest set bit.
    o_win   = w_pool & (-w_pool);
    o_vld   = |w_pool;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered fixed-priority bus arbiter with anti-starvation, ack handshake and timeout abort.
// Optional macro BUS_ARBITER_LOCK_EN adds i_m_lock so an owner can hold the bus across acks.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NM           = NM_DEF,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NM-1:0]     i_m_req,
  input  logic [16*NM-1:0]  i_m_addr,
  input  logic [8*NM-1:0]   i_m_dat,
  input  logic [NM-1:0]     i_m_we,
`ifdef BUS_ARBITER_LOCK_EN
  input  logic [NM-1:0]     i_m_lock,
`endif
  output logic [NM-1:0]     o_m_ack,
  output logic [NM-1:0]     o_m_err,
  output logic [NM-1:0]     o_m_gnt,
  output logic [15:0]       o_addr,
  output logic [7:0]        o_dat,
  output logic              o_we,
  output logic              o_cs,
  input  logic              i_ack
);

  localparam logic [CNT_W-1:0] LIM     = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NM-1:0]    r_gnt;
  logic [NM-1:0]    w_gnt_nxt;
  logic [NM-1:0]    r_m_ack;
  logic [NM-1:0]    w_ack_nxt;
  logic [NM-1:0]    r_m_err;
  logic [NM-1:0]    w_err_nxt;
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] w_tcnt_nxt;
  logic [CNT_W-1:0] r_wcnt [NM];

  logic [NM-1:0]    w_starved;
  logic [NM-1:0]    w_win;
  logic             w_win_vld;
  logic             w_own_req;
  logic             w_grant_new;
  logic             w_keep;

  for (genvar g = 0; g < NM; g++) begin : g_starve
    assign w_starved[g] = (r_wcnt[g] == LIM);
  end

  // r_gnt is zero in IDLE, so the owner exclusion only bites at a BUSY ack boundary.
  bus_arb_pick #(
    .NM(NM)
  ) u_pick (
    .i_req     (i_m_req),
    .i_excl    (r_gnt),
    .i_starved (w_starved),
    .o_win     (w_win),
    .o_vld     (w_win_vld)
  );

  assign w_own_req = |(r_gnt & i_m_req);

`ifdef BUS_ARBITER_LOCK_EN
  // A starved waiting master overrides the owner's lock at the ack boundary.
  assign w_keep = (|(r_gnt & i_m_lock)) && !(|(w_starved & i_m_req & ~r_gnt));
`else
  assign w_keep = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_tcnt_nxt  = r_tcnt;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_grant_new = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_gnt_nxt   = w_win;
          w_tcnt_nxt  = '0;
          w_state_nxt = ST_BUSY;
          w_grant_new = 1'b1;
        end
      end
      ST_BUSY: begin
        w_tcnt_nxt = r_tcnt + CNT_W'(1);
        // Ack outranks both a dropped request and a timeout in the same cycle.
        if (i_ack) begin
          w_ack_nxt  = r_gnt;
          w_tcnt_nxt = '0;
          if (!w_keep) begin
            if (w_win_vld) begin
              w_gnt_nxt   = w_win;
              w_grant_new = 1'b1;
            end else begin
              w_gnt_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end else if (!w_own_req) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == TO_LAST) begin
          w_err_nxt   = r_gnt;
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_tcnt  <= '0;
      r_m_ack <= '0;
      r_m_err <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_m_ack <= w_ack_nxt;
      r_m_err <= w_err_nxt;
    end
  end

  // The owner's counter holds while granted, so a locked owner keeps its count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NM; k++) r_wcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (!i_m_req[k]) begin
          r_wcnt[k] <= '0;
        end else if (w_grant_new && w_gnt_nxt[k]) begin
          r_wcnt[k] <= '0;
        end else if (!r_gnt[k] && (r_wcnt[k] != LIM)) begin
          r_wcnt[k] <= r_wcnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_addr = '0;
    o_dat  = '0;
    o_we   = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (r_gnt[k]) begin
        o_addr |= i_m_addr[16*k +: 16];
        o_dat  |= i_m_dat[8*k +: 8];
        o_we   |= i_m_we[k];
      end
    end
  end

  assign o_cs    = (r_state == ST_BUSY);
  assign o_m_gnt = r_gnt;
  assign o_m_ack = r_m_ack;
  assign o_m_err = r_m_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (STARVE_LIMIT=8, TIMEOUT=16).
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] m_addr;
  logic [23:0] m_dat;
  logic [2:0]  m_we;
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [2:0]  m_gnt;
  logic [15:0] addr;
  logic [7:0]  dat;
  logic        we;
  logic        cs;
  logic        ack;
`ifdef BUS_ARBITER_LOCK_EN
  logic [2:0]  lock;
`endif

  int n_chk;
  int n_fail;

  bus_arbiter #(
    .NM(3),
    .STARVE_LIMIT(8),
    .TIMEOUT(16)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_m_req   (req),
    .i_m_addr  (m_addr),
    .i_m_dat   (m_dat),
    .i_m_we    (m_we),
`ifdef BUS_ARBITER_LOCK_EN
    .i_m_lock  (lock),
`endif
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_m_gnt   (m_gnt),
    .o_addr    (addr),
    .o_dat     (dat),
    .o_we      (we),
    .o_cs      (cs),
    .i_ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic [15:0] a, input logic [7:0] d, input logic w);
    m_addr[16*k +: 16] = a;
    m_dat[8*k +: 8]    = d;
    m_we[k]            = w;
  endtask

  logic [2:0] starve_exp [10];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = '0;
    m_addr = '0;
    m_dat  = '0;
    m_we   = '0;
    ack    = 1'b0;
`ifdef BUS_ARBITER_LOCK_EN
    lock   = '0;
`endif
    starve_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001,
                   3'b010, 3'b001, 3'b010, 3'b100, 3'b001};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs",   32'(cs),    32'h0);
    chk("rst_gnt",  32'(m_gnt), 32'h0);
    chk("rst_addr", 32'(addr),  32'h0);
    chk("rst_dat",  32'(dat),   32'h0);
    chk("rst_we",   32'(we),    32'h0);
    chk("rst_ack",  32'(m_ack), 32'h0);
    chk("rst_err",  32'(m_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_cs",   32'(cs),    32'h0);
    chk("idle_gnt",  32'(m_gnt), 32'h0);
    chk("idle_addr", 32'(addr),  32'h0);

    // CPU write, acked in the second BUSY cycle
    set_m(M_CPU, 16'h1234, 8'hA5, 1'b1);
    req[M_CPU] = 1'b1;
    chk("cpu_cs_pre", 32'(cs), 32'h0);
    tick();
    chk("cpu_cs",   32'(cs),    32'h1);
    chk("cpu_gnt",  32'(m_gnt), 32'h4);
    chk("cpu_addr", 32'(addr),  32'h1234);
    chk("cpu_dat",  32'(dat),   32'hA5);
    chk("cpu_we",   32'(we),    32'h1);
    tick();
    chk("cpu_ack_early", 32'(m_ack), 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("cpu_ack",      32'(m_ack), 32'h4);
    chk("cpu_cs_done",  32'(cs),    32'h0);
    chk("cpu_gnt_done", 32'(m_gnt), 32'h0);
    req[M_CPU] = 1'b0;
    m_we = '0;
    tick();
    chk("cpu_ack_once", 32'(m_ack), 32'h0);

    // Simultaneous requests, one-cycle acks, back-to-back grants
    set_m(M_VGA,  16'h1000, 8'h11, 1'b0);
    set_m(M_UART, 16'h2000, 8'h22, 1'b0);
    set_m(M_CPU,  16'h3000, 8'h33, 1'b0);
    req = 3'b111;
    ack = 1'b1;
    tick();
    chk("rr_gnt0",  32'(m_gnt), 32'h1);
    chk("rr_addr0", 32'(addr),  32'h1000);
    tick();
    chk("rr_ack0",  32'(m_ack), 32'h1);
    chk("rr_gnt1",  32'(m_gnt), 32'h2);
    chk("rr_addr1", 32'(addr),  32'h2000);
    req[M_VGA] = 1'b0;
    tick();
    chk("rr_ack1", 32'(m_ack), 32'h2);
    chk("rr_gnt2", 32'(m_gnt), 32'h4);
    chk("rr_cs2",  32'(cs),    32'h1);
    req[M_UART] = 1'b0;
    tick();
    chk("rr_ack2", 32'(m_ack), 32'h4);
    chk("rr_cs3",  32'(cs),    32'h0);
    req[M_CPU] = 1'b0;
    ack = 1'b0;
    tick();

    // VGA and UART hog the bus; CPU wins once its wait count saturates
    req = 3'b111;
    ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("starve_gnt%0d", i), 32'(m_gnt), 32'(starve_exp[i]));
    end
    req = '0;
    ack = 1'b0;
    tick();
    tick();
    chk("starve_idle", 32'(cs), 32'h0);

    // UART never acked: abort after 16 BUSY cycles, stray ack ignored
    req[M_UART] = 1'b1;
    tick();
    chk("to_gnt", 32'(m_gnt), 32'h2);
    repeat (15) tick();
    chk("to_err_early", 32'(m_err), 32'h0);
    chk("to_cs_late",   32'(cs),    32'h1);
    tick();
    chk("to_err",       32'(m_err), 32'h2);
    chk("to_cs_after",  32'(cs),    32'h0);
    chk("to_gnt_after", 32'(m_gnt), 32'h0);
    req[M_UART] = 1'b0;
    ack = 1'b1;
    tick();
    chk("stray_ack", 32'(m_ack), 32'h0);
    ack = 1'b0;
    tick();
    chk("stray_ack2",  32'(m_ack), 32'h0);
    chk("to_err_once", 32'(m_err), 32'h0);

    // Ack in the same cycle the timeout would fire
    req[M_UART] = 1'b1;
    tick();
    repeat (15) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("co_ack", 32'(m_ack), 32'h2);
    chk("co_err", 32'(m_err), 32'h0);
    req[M_UART] = 1'b0;
    tick();

    // Owner abandons before ack
    req[M_CPU] = 1'b1;
    tick();
    chk("ab_cs", 32'(cs), 32'h1);
    req[M_CPU] = 1'b0;
    tick();
    chk("ab_cs_after", 32'(cs),    32'h0);
    chk("ab_ack",      32'(m_ack), 32'h0);
    tick();

    // Asynchronous reset in the middle of a BUSY cycle
    set_m(M_CPU, 16'hBEEF, 8'h5A, 1'b1);
    req[M_CPU] = 1'b1;
    tick();
    chk("rs_cs_busy", 32'(cs), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_cs",   32'(cs),    32'h0);
    chk("rs_gnt",  32'(m_gnt), 32'h0);
    chk("rs_addr", 32'(addr),  32'h0);
    chk("rs_we",   32'(we),    32'h0);
    req = '0;
    m_we = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef BUS_ARBITER_LOCK_EN
    // CPU holds the bus for two locked transactions, then UART
    req[M_CPU]  = 1'b1;
    lock[M_CPU] = 1'b1;
    tick();
    chk("lk_gnt0", 32'(m_gnt), 32'h4);
    req[M_UART] = 1'b1;
    ack = 1'b1;
    tick();
    chk("lk_ack0", 32'(m_ack), 32'h4);
    chk("lk_gnt1", 32'(m_gnt), 32'h4);
    lock[M_CPU] = 1'b0;
    tick();
    chk("lk_ack1", 32'(m_ack), 32'h4);
    chk("lk_gnt2", 32'(m_gnt), 32'h2);
    req[M_CPU] = 1'b0;
    tick();
    chk("lk_ack2", 32'(m_ack), 32'h2);
    req[M_UART] = 1'b0;
    ack = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences the shared 8-bit-data / 16-bit-address memory bus between three masters: VGA fetch, UART bridge and CPU.
- Uses registered, fixed-priority arbitration with an anti-starvation override, a per-transaction ack handshake and a bus-timeout abort.
- Sits between the masters and the memory/peripheral decode in the top-level shell, replacing the ad-hoc per-cycle priority mux there.

Parameters:
- NM, 3, number of masters; index 0 has the highest priority (0 = VGA, 1 = UART, 2 = CPU).
- STARVE_LIMIT, 8, cycles a requester may wait before it is promoted above all others; range 1..255.
- TIMEOUT, 16, cycles without i_ack before the transaction is aborted; range 2..255.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_m_req  in  NM  per-master request; held high until that master's o_m_ack or o_m_err.
- i_m_addr  in  16*NM  per-master address; master k uses bits [16k+15:16k].
- i_m_dat  in  8*NM  per-master write data.
- i_m_we  in  NM  per-master write enable.
- o_m_ack  out  NM  one-cycle completion pulse to the owning master.
- o_m_err  out  NM  one-cycle timeout-abort pulse to the owning master.
- o_m_gnt  out  NM  one-hot current owner; all zero when idle.
- o_addr  out  16  shared bus address.
- o_dat  out  8  shared bus write data.
- o_we  out  1  shared bus write enable.
- o_cs  out  1  shared bus chip select.
- i_ack  in  1  slave completion for the current bus cycle.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; gnt = 0; all counters 0.
  - o_cs = 0, o_we = 0, o_addr = 0, o_dat = 0, o_m_ack = 0, o_m_err = 0.
- States: IDLE and BUSY.
- IDLE:
  - Evaluate the pick on every cycle with any i_m_req set.
  - Register gnt one-hot and go to BUSY.
  - Bus is driven in the next cycle; request-to-o_cs latency is 1 cycle.
- BUSY:
  - o_addr, o_dat, o_we come from the granted master through a mux on registered gnt; o_cs = 1.
  - On i_ack: pulse o_m_ack[owner] in the same cycle i_ack is seen, registered so it is visible on the following edge. Re-arbitrate in that same cycle, excluding the owner's current request. A new grant starts back-to-back with no idle cycle; with no other request, go to IDLE.
  - If the owner drops i_m_req before i_ack: abandon the transaction, no ack, go to IDLE next cycle, o_cs = 0.
  - Timeout counter: cleared on grant, incremented each BUSY cycle. When it reaches TIMEOUT-1 without i_ack, pulse o_m_err[owner], go to IDLE, o_cs = 0. A late i_ack in IDLE is ignored.
- Pick:
  - Default: lowest-index requesting master wins.
  - Each master has an 8-bit wait counter. It increments while that master requests and is not granted, saturates at STARVE_LIMIT, and clears on its grant or when its request drops.
  - Any master whose counter equals STARVE_LIMIT wins over non-starved masters. Among several starved masters, the lowest index wins.
- Simultaneous events:
  - i_ack and timeout in the same cycle: i_ack wins and ack is pulsed, no err.
  - Owner's request drop and i_ack in the same cycle: ack is pulsed.
- Grant never changes mid-transaction; o_m_gnt is stable from grant through ack, err or abandon.

Optional Feature:
- Macro BUS_ARBITER_LOCK_EN.
- When defined:
  - Adds input i_m_lock [NM].
  - If the owner has i_m_lock high when its ack is issued and still requests next cycle, it keeps the grant with no re-arbitration and its wait counter is not reset.
  - Other masters' wait counters keep running; a starved master breaks the lock at the next ack boundary.
  - Used for CPU read-modify-write and UART burst loads.
- When undefined: no i_m_lock port; every ack boundary re-arbitrates.

Decomposition:
- Package bus_arb_pkg holds:
  - NM default and master index constants M_VGA = 0, M_UART = 1, M_CPU = 2.
  - State encoding (IDLE = 0, BUSY = 1).
  - Counter width constant (8).
- One sub-module, bus_arb_pick: combinational, takes req, exclude mask and starved flags, returns one-hot winner and valid.
- The main module keeps the FSM, counters and output mux.

Test Plan:
- Reset then all requests low -> o_cs = 0, o_m_gnt = 000, o_addr = 0x0000 indefinitely; mid-BUSY reset drop -> outputs return to 0 immediately.
- CPU requests write addr 0x1234, dat 0xA5; i_ack after 2 BUSY cycles -> o_cs high 1 cycle after req, o_we = 1, o_m_ack[2] single pulse, return to IDLE.
- VGA, UART and CPU request simultaneously, each acked after 1 cycle -> grant order VGA, UART, CPU, back-to-back with no idle cycle between them.
- VGA requests continuously, CPU requests; STARVE_LIMIT = 8 -> CPU granted at the first ack boundary after waiting 8 cycles, then VGA resumes.
- UART granted, i_ack never asserted, TIMEOUT = 16 -> o_m_err[1] pulses after 16 BUSY cycles, o_cs drops; a later stray i_ack produces no o_m_ack.
- BUSY with i_ack and timeout coincident -> o_m_ack pulses, o_m_err stays 0. With BUSY_ARBITER_LOCK_EN defined (macro BUS_ARBITER_LOCK_EN), CPU lock held for 2 transactions while UART requests -> CPU owns both, UART granted next.
